// File: rtl/hl_ui_pkg.sv
`default_nettype none
// ==================================================================
// hl_ui_pkg: shared UI button indices, timing defaults and helpers
// Revision: 1.0
// ==================================================================
package hl_ui_pkg;

  localparam int BTN_IDX_MODE   = 0;
  localparam int BTN_IDX_ECHO   = 1;
  localparam int BTN_IDX_NOISE  = 2;
  localparam int BTN_IDX_FILTER = 3;
  localparam int N_UI_BTN       = 4;

  localparam int DEB_20MS_50MHZ = 1000000;
  localparam int LONG_1S_50MHZ  = 50000000;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hl_btn_chan.sv
`default_nettype none
// ==================================================================
// hl_btn_chan: one button channel - sync, debounce, edges, long press
// Revision: 1.0
// ==================================================================
module hl_btn_chan
  import hl_ui_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEB_20MS_50MHZ,
  parameter int LONG_CYCLES     = LONG_1S_50MHZ,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int c_deb_w = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [c_deb_w-1:0] c_deb_last = c_deb_w'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $fatal(1, "hl_btn_chan: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $fatal(1, "hl_btn_chan: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   w_sync;
  logic                   stable_q, stable_d;
  logic [c_deb_w-1:0]     deb_cnt_q, deb_cnt_d;
  logic                   press_q, release_q;

  assign w_sync = sync_q[SYNC_STAGES-1];

  // Polarity is normalised before the first flop so reset means "released".
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i ^ ACTIVE_LOW};
    end
  end

  always_comb begin
    stable_d  = stable_q;
    deb_cnt_d = '0;
    if (w_sync != stable_q) begin
      if (deb_cnt_q == c_deb_last) begin
        stable_d = w_sync;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q  <= 1'b0;
      deb_cnt_q <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      stable_q  <= stable_d;
      deb_cnt_q <= deb_cnt_d;
      press_q   <= stable_d & ~stable_q;
      release_q <= ~stable_d & stable_q;
    end
  end

  assign level_o   = stable_q;
  assign press_o   = press_q;
  assign release_o = release_q;

  if (LONG_CYCLES > 0) begin : g_long
    localparam int c_hold_w = cnt_width(LONG_CYCLES);
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(LONG_CYCLES - 1);

    logic [c_hold_w-1:0] hold_cnt_q, hold_cnt_d;
    logic                long_done_q, long_done_d;
    logic                long_q, long_d;

    // Counter parks at its last value once the pulse has fired for this press.
    always_comb begin
      hold_cnt_d  = hold_cnt_q;
      long_done_d = long_done_q;
      long_d      = 1'b0;
      if (!stable_q) begin
        hold_cnt_d  = '0;
        long_done_d = 1'b0;
      end else if (!long_done_q) begin
        if (hold_cnt_q == c_hold_last) begin
          long_d      = 1'b1;
          long_done_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        hold_cnt_q  <= '0;
        long_done_q <= 1'b0;
        long_q      <= 1'b0;
      end else begin
        hold_cnt_q  <= hold_cnt_d;
        long_done_q <= long_done_d;
        long_q      <= long_d;
      end
    end

    assign long_o = long_q;
  end else begin : g_no_long
    assign long_o = 1'b0;
  end

endmodule
`default_nettype wire

// File: rtl/hl_btn_conditioner.sv
`default_nettype none
// ==================================================================
// hl_btn_conditioner: N independent debounced pushbutton channels
// Revision: 1.0
// ==================================================================
module hl_btn_conditioner
  import hl_ui_pkg::*;
#(
  parameter int N_BTN           = N_UI_BTN,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEB_20MS_50MHZ,
  parameter int LONG_CYCLES     = LONG_1S_50MHZ,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    hl_btn_chan #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .raw_i     (btn_raw[g]),
      .level_o   (btn_level[g]),
      .press_o   (btn_press[g]),
      .release_o (btn_release[g]),
      .long_o    (btn_long[g])
    );
  end

endmodule
`default_nettype wire

// File: doc/hl_btn_conditioner.md
Name: hl_btn_conditioner

Overview:
- Producer end of the button interface consumed by hl_mode_fsm.
- Takes raw, asynchronous, bouncing board pushbuttons (mode, echo, noise, filter) and synchronises, debounces and edge-detects them.
- Emits clean single-cycle press pulses on btn_press, which drive btn_mode/btn_echo/btn_noise/btn_filter of the mode FSM.
- Also provides debounced levels, release pulses and a long-press pulse for future UI use.

Parameters:
- N_BTN, 4, number of independent button channels.
- SYNC_STAGES, 2, synchroniser flip-flop depth; must be >= 2.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a change; must be >= 1; 20 ms at 50 MHz.
- LONG_CYCLES, 50000000, cycles a debounced press must persist before btn_long fires; 0 disables btn_long.
- ACTIVE_LOW, 1, when 1, btn_raw is inverted at the input (board buttons read 0 when pressed).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- btn_raw  in  N_BTN  raw asynchronous button pins.
- btn_level  out  N_BTN  debounced pressed level, active-high.
- btn_press  out  N_BTN  one-cycle pulse on each debounced press.
- btn_release  out  N_BTN  one-cycle pulse on each debounced release.
- btn_long  out  N_BTN  one-cycle pulse once per press after LONG_CYCLES held.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst; sampled only on rising clk.
- Reset values:
  - all outputs 0;
  - synchroniser registers 0, post-inversion value ("released");
  - stable state 0; debounce counter 0; hold counter 0; long_done 0.
- Channels are fully independent; simultaneous activity on any channels is handled in parallel with no priority.
- Input path: raw bit is XORed with ACTIVE_LOW, then passed through a SYNC_STAGES flip-flop chain; sync = last stage.
- Debounce, per channel, per clock:
  - sync == stable: deb_cnt <= 0.
  - sync != stable and deb_cnt < DEBOUNCE_CYCLES-1: deb_cnt <= deb_cnt+1.
  - sync != stable and deb_cnt == DEBOUNCE_CYCLES-1: stable <= sync, deb_cnt <= 0.
  - deb_cnt width is clog2(DEBOUNCE_CYCLES), minimum 1 bit; it never wraps.
- Latency: btn_level changes on clock edge number SYNC_STAGES+DEBOUNCE_CYCLES, counting as edge 1 the first edge that samples the new raw value, provided the value is held throughout.
- Glitches: any bounce shorter than DEBOUNCE_CYCLES synchronised cycles resets the count; btn_level does not change.
- btn_level is the stable register.
- Edge pulses:
  - btn_press is high for exactly the one cycle after the edge on which stable goes 0->1, coincident with btn_level first reading 1.
  - btn_release is the same for 1->0.
  - Press and release are never both high on one channel in the same cycle.
- Long press, LONG_CYCLES > 0:
  - hold_cnt clears when stable == 0 and increments while stable == 1 and long_done == 0.
  - When hold_cnt reaches LONG_CYCLES-1 with stable == 1: btn_long pulses one cycle and long_done <= 1.
  - hold_cnt saturates; long_done clears on release.
  - Exactly one btn_long per press, asserted on edge LONG_CYCLES after btn_level rises.
- Long press, LONG_CYCLES == 0: btn_long is tied 0 and hold logic is removed.
- Reset mid-operation:
  - all state returns to reset values on the next edge; any pulse in flight is dropped.
  - A button held through reset release generates a fresh press after SYNC_STAGES+DEBOUNCE_CYCLES edges. This is intended.
- Elaboration check: SYNC_STAGES < 2 or DEBOUNCE_CYCLES < 1 is a fatal elaboration error.

Decomposition:
- Package hl_ui_pkg holds:
  - channel indices BTN_IDX_MODE=0, BTN_IDX_ECHO=1, BTN_IDX_NOISE=2, BTN_IDX_FILTER=3;
  - N_UI_BTN=4;
  - default timing constants DEB_20MS_50MHZ=1000000 and LONG_1S_50MHZ=50000000.
- Sub-module hl_btn_chan: one channel containing synchroniser, debounce counter, edge detector and long-press counter. hl_btn_conditioner instantiates N_BTN copies in a generate loop.

Test Plan:
- Bench parameters for all scenarios: DEBOUNCE_CYCLES=4, SYNC_STAGES=2, LONG_CYCLES=10, ACTIVE_LOW=0.
- Reset: hold rst 3 cycles with btn_raw=4'b1111 -> all outputs 0 during reset. After release, btn_press=4'b1111 pulses once on edge 6 and btn_level=4'b1111.
- Clean press on ch1: raw 0->1 sampled at edge 1 -> btn_level[1]=1 and btn_press[1]=1 after edge 6, btn_press[1]=0 after edge 7. No activity on other channels.
- Bounce on ch0: raw high 3 cycles, low 1, high 3, low -> btn_level[0] stays 0 and no pulses. Then hold high 4+ cycles -> exactly one press.
- Long press on ch2: hold 20 cycles after btn_level rises -> single btn_long[2] pulse 10 edges after the level rise. On release, btn_release[2] pulses once, 6 edges after raw falls.
- Simultaneous channels: ch0 press while ch3 releases in the same cycle -> btn_press[0] and btn_release[3] both pulse in the same cycle.
- Mid-press reset: assert rst while btn_level[1]=1 -> outputs 0 next edge. Keep raw high after reset release -> new btn_press[1] 6 edges later.
- ACTIVE_LOW=1 variant: raw 1->0 -> btn_press pulses after 6 edges.
- FSM integration: btn_press[0] feeds hl_mode_fsm btn_mode. Two presses -> mode_is_loss toggles twice, back to its reset value.
